onchip_mem_stream_reader: RTL and testbench
===========================================

# onchip_mem_stream_reader

Avalon-MM read master that sits directly in front of the 8192×32 single-port on-chip RAM. It streams a CSR-programmed window of words out of that RAM onto an Avalon-ST source with ready/valid backpressure. A small output FIFO decouples the RAM's fixed 1-cycle read latency from the downstream sink. The Nios CPU programs the block through a 4-register CSR slave and is signalled by a done flag and an optional IRQ.

## Interface

- `ADDR_W`, 13: RAM word-address width.
- `DATA_W`, 32: data width.
- `FIFO_DEPTH`, 4: output FIFO entries (power of 2, ≥2).
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `csr_address` in 2: 0 START, 1 LENGTH, 2 CONTROL, 3 STATUS.
- `csr_chipselect`, `csr_write`, `csr_read` in 1: CSR slave strobes.
- `csr_writedata` in 32 / `csr_readdata` out 32: CSR data, 1-cycle registered read latency.
- `mem_address` out ADDR_W: RAM word address.
- `mem_chipselect` out 1: high in each read-issue cycle.
- `mem_write` out 1: tied 0.
- `mem_byteenable` out 4: tied 4'hF.
- `mem_clken` out 1: tied 1.
- `mem_readdata` in DATA_W: RAM read data, valid the cycle after issue.
- `src_data` out DATA_W, `src_valid` out 1, `src_ready` in 1: stream source.
- `src_startofpacket`, `src_endofpacket` out 1: first / last word markers.
- `irq` out 1: level interrupt.

## Operation

**CSR map**
- START[12:0]: first word address.
- LENGTH[13:0]: word count, 0..8192. Values above 8192 saturate to 8192.
- CONTROL, write-only:
  - bit0 GO (self-clearing pulse).
  - bit1 IE (persistent; reads back in STATUS[2]).
  - bit2 ABORT (pulse).
- STATUS:
  - bit0 BUSY.
  - bit1 DONE (sticky; write 1 to STATUS bit1 to clear).
  - bit2 IE.
- Writes to START and LENGTH while BUSY are ignored.

**FSM states: IDLE, RUN, DRAIN**
- **IDLE → RUN** on GO with LENGTH≠0. The block latches the address counter to START and the issue and accept counters to LENGTH.
- **GO with LENGTH=0**: stay in IDLE, set DONE next cycle, emit no stream words.
- **GO while BUSY**: ignored.
- **RUN**:
  - Issues one read per cycle while issue_count≠0 and (fifo_count + inflight) < FIFO_DEPTH.
  - inflight is a 1-bit flag set on issue. It clears on the following cycle, when `mem_readdata` is written into the FIFO.
  - mem_address increments modulo 2^13, so 0x1FFF wraps to 0x0000.
  - RUN → DRAIN when the last read is issued.
- **DRAIN**: no issues. The block waits for the word tagged EOP to be accepted (src_valid & src_ready). It then goes to IDLE, sets DONE and clears BUSY.
- **ABORT in RUN or DRAIN**:
  - Stops issuing, flushes the FIFO and discards any in-flight word.
  - Deasserts src_valid next cycle and returns to IDLE.
  - DONE is not set.
- **ABORT in IDLE**: no effect.
- **Packet markers**:
  - The FIFO stores SOP and EOP alongside each word.
  - SOP is set on the word from the first issue; EOP on the word from the last issue.
  - LENGTH=1 sets both SOP and EOP on the same word.
- **Stream rules**:
  - src_data, SOP and EOP are held stable while src_valid is high and src_ready is low.
  - src_valid = FIFO not empty.
  - No word is dropped or duplicated under any backpressure pattern.
- **FIFO**: a simultaneous push and pop with the FIFO full or empty is legal and keeps the count consistent. The issue rule guarantees a push never targets a full FIFO.
- **irq** = DONE & IE, registered.
- **Reset values**: all outputs 0 except the tied outputs (mem_byteenable = 4'hF, mem_clken = 1). State IDLE, FIFO empty, DONE=0, IE=0. Reset mid-transfer abandons the transfer immediately.

## Timing

- GO written in cycle 0 (sampled at the end of cycle 0):
  - first mem_chipselect in cycle 1;
  - data captured into the FIFO at the end of cycle 2;
  - src_valid high in cycle 3.
- With src_ready held high, throughput is one word per cycle. An N-word transfer shows src_valid in cycles 3..N+2.
- BUSY reads 1 from cycle 1 until the cycle after the EOP handshake.
- DONE and BUSY=0 are visible in cycle E+1, where E is the EOP handshake cycle. irq rises in cycle E+2.
- CSR read: csr_readdata is valid the cycle after csr_read & csr_chipselect, and 0 otherwise.
- Backpressure: with the FIFO full, issuing resumes the cycle after a pop. At most FIFO_DEPTH words are ever buffered.

## Test plan

- **Basic transfer**: RAM[0x10..0x13] = A0..A3, START=0x0010, LENGTH=4, GO, src_ready=1.
  - Required: A0..A3 in cycles 3..6, SOP with A0, EOP with A3.
  - DONE=1 and BUSY=0 in cycle 7; irq=1 in cycle 8 with IE=1.
- **Backpressure**: LENGTH=16, src_ready low for cycles 0..20, then alternating.
  - Required: exactly 4 words buffered, mem_chipselect idle while full.
  - All 16 words delivered in order, no duplicates.
- **Wrap**: START=0x1FFE, LENGTH=4.
  - Required: mem_address sequence 1FFE, 1FFF, 0000, 0001; data in the same order.
- **Degenerate lengths**:
  - LENGTH=0 + GO: no mem_chipselect, no src_valid, DONE=1 in cycle 1.
  - LENGTH=1: a single word with both SOP and EOP.
- **Abort**: LENGTH=100, ABORT after 10 handshakes.
  - Required: src_valid=0 next cycle, BUSY=0, DONE=0.
  - A new GO then restarts cleanly, with SOP on the first word.
- **Reset mid-transfer**: reset_n low in cycle 5 of a 32-word transfer.
  - Required: all outputs 0 immediately (tied outputs excepted); FIFO empty after release; STATUS=0.

Source files
------------

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master streaming a CSR-programmed window of on-chip RAM words
// onto an Avalon-ST source through a small output FIFO.
module onchip_mem_stream_reader #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_startofpacket,
    output logic              src_endofpacket,
    output logic              irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] start_reg;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  len_in;
    logic              ie;
    logic              done;
    logic              inflight;
    logic              inflight_sop;
    logic              inflight_eop;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic              fifo_sop  [FIFO_DEPTH];
    logic              fifo_eop  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_count;
    logic [PTR_W+1:0]  occupancy;

    logic csr_wr;
    logic busy;
    logic go_req;
    logic abort_req;
    logic start_go;
    logic abort_act;
    logic issue;
    logic push;
    logic pop;
    logic fifo_nonempty;
    logic eop_pop;
    logic done_set;
    logic done_clr;
    logic unused_wdata;

    always_comb begin
        csr_wr        = csr_chipselect & csr_write;
        busy          = (state != S_IDLE);
        go_req        = csr_wr && (csr_address == 2'd2) && csr_writedata[0];
        abort_req     = csr_wr && (csr_address == 2'd2) && csr_writedata[2];
        start_go      = go_req && !busy;
        abort_act     = abort_req && busy;
        len_in        = csr_writedata[LEN_W-1:0];
        // An in-flight read already owns a FIFO slot, so it counts toward occupancy.
        occupancy     = {1'b0, fifo_count} + {{(PTR_W+1){1'b0}}, inflight};
        issue         = (state == S_RUN) && (issue_cnt != '0) &&
                        (occupancy < (PTR_W+2)'(FIFO_DEPTH)) && !abort_act;
        fifo_nonempty = (fifo_count != '0);
        pop           = fifo_nonempty && src_ready;
        push          = inflight && !abort_act;
        eop_pop       = pop && fifo_eop[rd_ptr];
        done_set      = (start_go && (len_reg == '0)) ||
                        ((state == S_DRAIN) && eop_pop && !abort_act);
        done_clr      = csr_wr && (csr_address == 2'd3) && csr_writedata[1];
        unused_wdata  = ^csr_writedata[31:LEN_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            start_reg    <= '0;
            len_reg      <= '0;
            addr_q       <= '0;
            issue_cnt    <= '0;
            ie           <= 1'b0;
            done         <= 1'b0;
            irq          <= 1'b0;
            inflight     <= 1'b0;
            inflight_sop <= 1'b0;
            inflight_eop <= 1'b0;
        end else begin
            if (csr_wr && !busy) begin
                if (csr_address == 2'd0) start_reg <= csr_writedata[ADDR_W-1:0];
                if (csr_address == 2'd1) len_reg <= (len_in > LEN_MAX) ? LEN_MAX : len_in;
            end
            if (csr_wr && (csr_address == 2'd2)) ie <= csr_writedata[1];

            if (done_set)      done <= 1'b1;
            else if (done_clr) done <= 1'b0;
            irq <= done & ie;

            inflight     <= issue;
            inflight_sop <= issue && (issue_cnt == len_reg);
            inflight_eop <= issue && (issue_cnt == LEN_W'(1));
            if (issue) begin
                addr_q    <= addr_q + ADDR_W'(1);
                issue_cnt <= issue_cnt - LEN_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start_go && (len_reg != '0)) begin
                        state     <= S_RUN;
                        addr_q    <= start_reg;
                        issue_cnt <= len_reg;
                    end
                end
                S_RUN: begin
                    if (abort_act)                               state <= S_IDLE;
                    else if (issue && (issue_cnt == LEN_W'(1)))  state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (abort_act || eop_pop) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (abort_act) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_readdata;
            fifo_sop[wr_ptr]  <= inflight_sop;
            fifo_eop[wr_ptr]  <= inflight_eop;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_readdata <= '0;
        end else if (csr_chipselect && csr_read) begin
            case (csr_address)
                2'd0:    csr_readdata <= 32'(start_reg);
                2'd1:    csr_readdata <= 32'(len_reg);
                2'd3:    csr_readdata <= {29'd0, ie, done, busy};
                default: csr_readdata <= '0;
            endcase
        end else begin
            csr_readdata <= '0;
        end
    end

    // FIFO storage is not reset, so stream outputs are gated to read zero when empty.
    always_comb begin
        src_valid         = fifo_nonempty;
        src_data          = fifo_nonempty ? fifo_data[rd_ptr] : '0;
        src_startofpacket = fifo_nonempty && fifo_sop[rd_ptr];
        src_endofpacket   = fifo_nonempty && fifo_eop[rd_ptr];
        mem_chipselect    = issue;
        mem_address       = addr_q;
        mem_write         = 1'b0;
        mem_byteenable    = 4'hF;
        mem_clken         = 1'b1;
    end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Directed/randomized bench for onchip_mem_stream_reader with a RAM model and
// an expected-stream model derived from START/LENGTH arithmetic.
module tb_onchip_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  csr_address = '0;
    logic        csr_chipselect = 1'b0;
    logic        csr_write = 1'b0;
    logic        csr_read = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic [12:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic        mem_clken;
    logic [31:0] mem_readdata = '0;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready = 1'b0;
    logic        src_startofpacket;
    logic        src_endofpacket;
    logic        irq;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    onchip_mem_stream_reader #(.ADDR_W(13), .DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .csr_address(csr_address), .csr_chipselect(csr_chipselect),
        .csr_write(csr_write), .csr_read(csr_read),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .src_startofpacket(src_startofpacket), .src_endofpacket(src_endofpacket),
        .irq(irq)
    );

    // RAM model: one-cycle read latency
    logic [31:0] ram [8192];
    always @(posedge clk) if (mem_chipselect) mem_readdata <= ram[mem_address];

    // Monitor: handshakes, read issues, stability under backpressure
    logic [33:0] rx[$];
    int          rx_cyc[$];
    logic [12:0] cs_addr[$];
    int          cs_cyc[$];
    int          stab_err = 0;
    logic        pend = 1'b0;
    logic [33:0] pend_w = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            pend <= 1'b0;
        end else begin
            if (pend && !(src_valid && ({src_startofpacket, src_endofpacket, src_data} == pend_w)))
                stab_err <= stab_err + 1;
            if (mem_chipselect) begin
                cs_addr.push_back(mem_address);
                cs_cyc.push_back(cyc);
            end
            if (src_valid && src_ready) begin
                rx.push_back({src_startofpacket, src_endofpacket, src_data});
                rx_cyc.push_back(cyc);
            end
            pend   <= src_valid && !src_ready;
            pend_w <= {src_startofpacket, src_endofpacket, src_data};
        end
    end

    function automatic logic [33:0] exp_word(input int start, input int n, input int i);
        return {(i == 0), (i == n - 1), ram[(start + i) % 8192]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d, output int c);
        c = cyc;
        csr_chipselect = 1'b1; csr_write = 1'b1; csr_address = a; csr_writedata = d;
        tick;
        csr_chipselect = 1'b0; csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_chipselect = 1'b1; csr_read = 1'b1; csr_address = a;
        tick;
        csr_chipselect = 1'b0; csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic wait_rx(input int target, input int budget);
        for (int k = 0; k < budget && rx.size() < target; k++) tick;
    endtask

    task automatic chk_stream(input string tag, input int start, input int n, input int base);
        logic [63:0] obs;
        chk({tag, "_count"}, 64'(rx.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            obs = (base + i < rx.size()) ? 64'(rx[base + i]) : 64'hDEAD_0000_0000_0000;
            chk(tag, obs, 64'(exp_word(start, n, i)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g, c, rb, cb, s0, start;
        logic [31:0] d;

        for (int i = 0; i < 8192; i++) ram[i] = $urandom;

        repeat (3) tick;
        reset_n = 1'b1;
        tick;
        chk("rst_ctrl", {src_valid, src_startofpacket, src_endofpacket, mem_chipselect,
                         mem_write, irq, mem_clken, mem_byteenable},
                        {6'b0, 1'b1, 4'hF});
        chk("rst_data", src_data, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_rdata", csr_readdata, 0);
        csr_rd(2'd3, d);
        chk("rst_status", d, 0);

        csr_wr(2'd1, 32'h3FFF, c);
        csr_rd(2'd1, d);
        chk("len_sat", d, 32'h2000);

        // Basic transfer with exact cycle timing
        src_ready = 1'b1;
        start = 16;
        csr_wr(2'd0, 32'(start), c);
        csr_wr(2'd1, 4, c);
        rb = rx.size(); cb = cs_addr.size();
        csr_wr(2'd2, 32'h3, g);
        while (cyc < g + 6) tick;
        csr_rd(2'd3, d);
        chk("basic_busy", d, 32'h5);
        chk("basic_irq_low", irq, 0);
        csr_rd(2'd3, d);
        chk("basic_done", d, 32'h6);
        chk("basic_irq", irq, 1);
        wait_rx(rb + 4, 50);
        chk_stream("basic", start, 4, rb);
        chk("basic_first_cyc", 64'(rx_cyc[rb] - g), 3);
        chk("basic_last_cyc", 64'(rx_cyc[rb + 3] - g), 6);
        chk("basic_cs_cyc", 64'(cs_cyc[cb] - g), 1);
        chk("basic_cs_count", 64'(cs_addr.size() - cb), 4);
        csr_wr(2'd3, 32'h2, c);

        // Backpressure
        src_ready = 1'b0;
        start = $urandom_range(32'h200, 32'h1000);
        csr_wr(2'd0, 32'(start), c);
        csr_wr(2'd1, 16, c);
        rb = rx.size(); cb = cs_addr.size(); s0 = stab_err;
        csr_wr(2'd2, 32'h3, g);
        csr_wr(2'd0, 32'h0123, c);
        while (cyc < g + 21) tick;
        chk("bp_cs_stall", 64'(cs_addr.size() - cb), 4);
        chk("bp_valid", src_valid, 1);
        chk("bp_no_rx", 64'(rx.size() - rb), 0);
        for (int k = 0; k < 400 && rx.size() < rb + 16; k++) begin
            src_ready = (k % 2) == 0;
            tick;
        end
        src_ready = 1'b1;
        repeat (4) tick;
        chk_stream("bp", start, 16, rb);
        chk("bp_stable", 64'(stab_err - s0), 0);
        chk("bp_cs_total", 64'(cs_addr.size() - cb), 16);
        csr_rd(2'd0, d);
        chk("bp_start_locked", d, 32'(start));
        csr_wr(2'd3, 32'h2, c);

        // Address wrap
        start = 32'h1FFE;
        csr_wr(2'd0, 32'(start), c);
        csr_wr(2'd1, 4, c);
        rb = rx.size(); cb = cs_addr.size();
        csr_wr(2'd2, 32'h3, g);
        wait_rx(rb + 4, 50);
        repeat (3) tick;
        for (int i = 0; i < 4; i++)
            chk("wrap_addr", 64'(cs_addr[cb + i]), 64'((start + i) % 8192));
        chk_stream("wrap", start, 4, rb);
        csr_wr(2'd3, 32'h2, c);

        // LENGTH = 0
        csr_wr(2'd1, 0, c);
        rb = rx.size(); cb = cs_addr.size();
        csr_wr(2'd2, 32'h3, g);
        csr_rd(2'd3, d);
        chk("len0_done", d, 32'h6);
        repeat (5) tick;
        chk("len0_no_cs", 64'(cs_addr.size() - cb), 0);
        chk("len0_no_rx", 64'(rx.size() - rb), 0);
        csr_wr(2'd3, 32'h2, c);

        // LENGTH = 1
        start = $urandom_range(0, 8191);
        csr_wr(2'd0, 32'(start), c);
        csr_wr(2'd1, 1, c);
        rb = rx.size();
        csr_wr(2'd2, 32'h3, g);
        wait_rx(rb + 1, 50);
        repeat (3) tick;
        chk_stream("len1", start, 1, rb);
        csr_wr(2'd3, 32'h2, c);

        // Abort after 10 handshakes, then clean restart
        start = $urandom_range(0, 8191);
        csr_wr(2'd0, 32'(start), c);
        csr_wr(2'd1, 100, c);
        rb = rx.size();
        csr_wr(2'd2, 32'h3, g);
        wait_rx(rb + 10, 100);
        src_ready = 1'b0;
        csr_wr(2'd2, 32'h6, c);
        chk("abort_valid", src_valid, 0);
        chk("abort_rx_count", 64'(rx.size() - rb), 10);
        for (int i = 0; i < 10; i++)
            chk("abort_words", 64'(rx[rb + i]), 64'(exp_word(start, 100, i)));
        cb = cs_addr.size();
        src_ready = 1'b1;
        repeat (5) tick;
        chk("abort_no_cs", 64'(cs_addr.size() - cb), 0);
        chk("abort_no_rx", 64'(rx.size() - rb), 10);
        csr_rd(2'd3, d);
        chk("abort_status", d, 32'h4);
        start = $urandom_range(0, 8191);
        csr_wr(2'd0, 32'(start), c);
        csr_wr(2'd1, 3, c);
        rb = rx.size();
        csr_wr(2'd2, 32'h3, g);
        wait_rx(rb + 3, 50);
        repeat (3) tick;
        chk_stream("restart", start, 3, rb);
        csr_wr(2'd3, 32'h2, c);

        // Reset mid-transfer
        start = $urandom_range(0, 8191);
        csr_wr(2'd0, 32'(start), c);
        csr_wr(2'd1, 32, c);
        csr_wr(2'd2, 32'h3, g);
        while (cyc < g + 5) tick;
        chk("pre_rst_valid", src_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", {src_valid, src_startofpacket, src_endofpacket, mem_chipselect,
                             mem_write, irq, mem_clken, mem_byteenable},
                            {6'b0, 1'b1, 4'hF});
        chk("mid_rst_data", src_data, 0);
        chk("mid_rst_addr", mem_address, 0);
        chk("mid_rst_rdata", csr_readdata, 0);
        tick;
        tick;
        reset_n = 1'b1;
        tick;
        chk("post_rst_valid", src_valid, 0);
        csr_rd(2'd3, d);
        chk("post_rst_status", d, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
